// File: rtl/cve2_fetch_fifo_pkg.sv
// cve2_fetch_fifo_pkg: shared constants for the fetch FIFO.
// WORD_W   - width of a fetched bus word.
// OPC_FULL - low two bits of a halfword marking a full-width (non-compressed) instruction.
package cve2_fetch_fifo_pkg;
    localparam int unsigned WORD_W   = 32;
    localparam logic [1:0]  OPC_FULL = 2'b11;
endpackage

// File: rtl/cve2_fetch_fifo.sv
// cve2_fetch_fifo: instruction-word FIFO that realigns compressed/unaligned instructions for the IF stage.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i, in_addr_i       flush all entries and load a new instruction address
//   busy_o                   bit k = entry k+1 holds a word (throttles the bus requester)
//   in_valid_i/rdata/err     word-aligned bus response
//   out_valid_o/ready_i      instruction handshake towards IF
//   out_addr/rdata/err/err_plus2  instruction address, bits and fetch-error flags
module cve2_fetch_fifo
    import cve2_fetch_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    output logic [NUM_REQS-1:0] busy_o,
    input  logic              in_valid_i,
    input  logic [31:0]       in_addr_i,
    input  logic [WORD_W-1:0] in_rdata_i,
    input  logic              in_err_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_addr_o,
    output logic [WORD_W-1:0] out_rdata_o,
    output logic              out_err_o,
    output logic              out_err_plus2_o
);
    localparam int unsigned DEPTH = NUM_REQS + 1;

    logic [DEPTH-1:0]             valid_q, valid_d, err_q, err_d;
    logic [DEPTH-1:0][WORD_W-1:0] rdata_q, rdata_d;
    logic [31:1]                  addr_q;
    logic [WORD_W-1:0]            head_rdata;
    logic [15:0]                  second_lo;
    logic head_err, head_present, second_err, second_present;
    logic unaligned, compressed, split, hs, pop, push, placed;
    logic unused_addr_lsb;

    function automatic logic is_compressed(input logic [1:0] lsb);
        return lsb != OPC_FULL;
    endfunction

    // Empty slots are filled straight from the bus so a word can be used the cycle it arrives.
    assign head_present   = valid_q[0] | in_valid_i;
    assign head_rdata     = valid_q[0] ? rdata_q[0] : in_rdata_i;
    assign head_err       = valid_q[0] ? err_q[0] : in_err_i;
    assign second_present = valid_q[1] | (valid_q[0] & in_valid_i);
    assign second_lo      = valid_q[1] ? rdata_q[1][15:0] : in_rdata_i[15:0];
    assign second_err     = valid_q[1] ? err_q[1] : in_err_i;

    assign unaligned  = addr_q[1];
    assign compressed = is_compressed(unaligned ? head_rdata[17:16] : head_rdata[1:0]);
    // A 32-bit instruction straddling two words; a head error is reported without waiting for word two.
    assign split      = unaligned & ~compressed;

    assign out_valid_o     = ~clear_i & (split ? second_present | (head_present & head_err) : head_present);
    assign out_rdata_o     = unaligned ? {second_lo, head_rdata[31:16]} : head_rdata;
    assign out_addr_o      = {addr_q, 1'b0};
    assign out_err_o       = out_valid_o & (head_err | (split & second_present & second_err));
    assign out_err_plus2_o = out_valid_o & split & second_present & second_err & ~head_err;
    assign busy_o          = valid_q[DEPTH-1:1];
    assign unused_addr_lsb = in_addr_i[0];

    assign hs   = out_valid_o & out_ready_i;
    // An aligned compressed instruction leaves its upper half in the head word.
    assign pop  = hs & (unaligned | ~compressed);
    // A bypassed head word that is consumed in the same cycle is never stored.
    assign push = in_valid_i & ~(pop & ~valid_q[0]);

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        placed  = 1'b0;
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                valid_d[i] = valid_q[i+1];
                rdata_d[i] = rdata_q[i+1];
                err_d[i]   = err_q[i+1];
            end
            valid_d[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push && !placed && !valid_d[i]) begin
                valid_d[i] = 1'b1;
                rdata_d[i] = in_rdata_i;
                err_d[i]   = in_err_i;
                placed     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            addr_q  <= '0;
        end else if (clear_i) begin
            valid_q <= '0;
            addr_q  <= in_addr_i[31:1];
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (hs) addr_q <= addr_q + (compressed ? 31'd1 : 31'd2);
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i && (&valid_q) && !pop && !clear_i));
endmodule
